// File: rtl/el2_dec_pmp_scan_ctl.sv
// ---------------------------------------------------------------------------
// el2_dec_pmp_scan_ctl
//
// Shared PMP permission-check scheduler. Two requesters (0 = IFU fetch,
// 1 = LSU data) are arbitrated round-robin. One address is checked at a
// time by scanning the live PMP entry array ENTRIES_PER_CYCLE entries per
// cycle in ascending order. The scan stops at the first matching entry.
//
// Ports
//   clk, rst      core clock, synchronous active-high reset
//   req_valid     per-requester check request
//   req_addr      per-requester byte address
//   req_acc       per-requester access type (0 R, 1 W, 2 X, 3 reserved)
//   req_umode     per-requester privilege (1 = U-mode, 0 = M-mode)
//   req_ready     request accepted this cycle (arbitration winner, IDLE only)
//   pmp_pmpcfg    per-entry cfg byte {L,2'b0,A[1:0],X,W,R}
//   pmp_pmpaddr   per-entry word address (bits 31:30 ignored)
//   pmp_cfg_wr    a pmpcfg/pmpaddr CSR write commits this cycle
//   rsp_valid     response available (held until rsp_ready)
//   rsp_ready     response consumed
//   rsp_id        requester that owns the response
//   rsp_err       1 = access denied
//   rsp_entry     matching entry index, 6'h3F = no match
// ---------------------------------------------------------------------------
module el2_dec_pmp_scan_ctl #(
  parameter int PMP_ENTRIES       = 16,
  parameter int ENTRIES_PER_CYCLE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req_valid,
  input  logic [1:0][31:0]            req_addr,
  input  logic [1:0][1:0]             req_acc,
  input  logic [1:0]                  req_umode,
  output logic [1:0]                  req_ready,
  input  logic [PMP_ENTRIES-1:0][7:0] pmp_pmpcfg,
  input  logic [PMP_ENTRIES-1:0][31:0] pmp_pmpaddr,
  input  logic                        pmp_cfg_wr,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_id,
  output logic                        rsp_err,
  output logic [5:0]                  rsp_entry
);

  localparam int NGROUPS = PMP_ENTRIES / ENTRIES_PER_CYCLE;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t        state;
  logic          rr_ptr;
  logic [GW-1:0] group;
  logic [29:0]   lat_wa;
  logic [1:0]    lat_acc;
  logic          lat_umode;
  logic          lat_id;

  // Request address bits 1:0 never take part in the check.
  logic unused_addr;
  assign unused_addr = ^{req_addr[0][1:0], req_addr[1][1:0]};

  // ------------------------------------------------------------------------
  // Arbitration: round-robin pointer only decides when both are valid.
  // ------------------------------------------------------------------------
  logic grant_id;

  // NOTE: every always_comb output gets a default before any condition, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    req_ready = '0;
    grant_id  = (&req_valid) ? rr_ptr : req_valid[1];
    if (state == IDLE && !rst && |req_valid) req_ready[grant_id] = 1'b1;
  end

  // ------------------------------------------------------------------------
  // Per-entry match and permission, evaluated against the latched address.
  // Arranged as [group][slot] so the active group is a plain select.
  // ------------------------------------------------------------------------
  logic [NGROUPS-1:0][ENTRIES_PER_CYCLE-1:0] hit;
  logic [NGROUPS-1:0][ENTRIES_PER_CYCLE-1:0] allow;

  for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_entry
    logic [7:0]  cfg;
    logic [29:0] pa;
    logic [29:0] pa_prev;
    logic [29:0] napot_ign;
    logic        perm;
    logic        unused_bits;

    assign cfg         = pmp_pmpcfg[i];
    assign pa          = pmp_pmpaddr[i][29:0];
    assign unused_bits = ^{pmp_pmpaddr[i][31:30], cfg[6:5]};

    if (i == 0) begin : g_first
      assign pa_prev = '0;
    end else begin : g_rest
      assign pa_prev = pmp_pmpaddr[i-1][29:0];
    end

    // pa ^ (pa + 1) sets the trailing ones and the zero that ends them; those
    // bits are don't-care. All-ones pa wraps to an all-ones mask (match all).
    assign napot_ign = pa ^ (pa + 30'd1);

    assign hit[i / ENTRIES_PER_CYCLE][i % ENTRIES_PER_CYCLE] =
        (cfg[4:3] == 2'd1) ? ((lat_wa >= pa_prev) && (lat_wa < pa)) :
        (cfg[4:3] == 2'd2) ? (lat_wa == pa) :
        (cfg[4:3] == 2'd3) ? (((lat_wa ^ pa) & ~napot_ign) == 30'd0) :
                             1'b0;

    assign perm = (lat_acc == 2'd0) ? cfg[0] :
                  (lat_acc == 2'd1) ? cfg[1] :
                  (lat_acc == 2'd2) ? cfg[2] : 1'b0;

    // Unlocked entries do not restrict M-mode; reserved access always fails.
    assign allow[i / ENTRIES_PER_CYCLE][i % ENTRIES_PER_CYCLE] =
        (lat_acc != 2'd3) && ((lat_umode || cfg[7]) ? perm : 1'b1);
  end

  // Lowest-index hit within the active group.
  logic [ENTRIES_PER_CYCLE-1:0] grp_vec;
  logic [ENTRIES_PER_CYCLE-1:0] grp_alw;
  logic                         grp_hit;
  logic                         grp_allow;
  logic [5:0]                   grp_off;
  logic [5:0]                   grp_entry;
  logic                         nomatch_allow;

  assign grp_vec = hit[group];
  assign grp_alw = allow[group];

  always_comb begin
    grp_hit   = 1'b0;
    grp_allow = 1'b0;
    grp_off   = '0;
    for (int j = ENTRIES_PER_CYCLE - 1; j >= 0; j--) begin
      if (grp_vec[j]) begin
        grp_hit   = 1'b1;
        grp_allow = grp_alw[j];
        grp_off   = 6'(j);
      end
    end
  end

  assign grp_entry     = 6'(group) * 6'(ENTRIES_PER_CYCLE) + grp_off;
  assign nomatch_allow = !lat_umode && (lat_acc != 2'd3);

  // ------------------------------------------------------------------------
  // Control FSM with registered response.
  // ------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout, so every register samples the
  // pre-edge values and ordering inside the block does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the request latches (lat_*) are deliberately left out of reset;
      // they are always loaded on accept before the scan reads them.
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      group     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_entry <= 6'h3F;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_ready) begin
            lat_wa    <= req_addr[grant_id][31:2];
            lat_acc   <= req_acc[grant_id];
            lat_umode <= req_umode[grant_id];
            lat_id    <= grant_id;
            rr_ptr    <= ~grant_id;
            group     <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (pmp_cfg_wr) begin
            // Table changed under us: throw away this group and restart.
            group <= '0;
          end else if (grp_hit) begin
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_err   <= ~grp_allow;
            rsp_entry <= grp_entry;
            state     <= RESP;
          end else if (group == GW'(NGROUPS - 1)) begin
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_err   <= ~nomatch_allow;
            rsp_entry <= 6'h3F;
            state     <= RESP;
          end else begin
            group <= group + GW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_el2_dec_pmp_scan_ctl.sv
// ---------------------------------------------------------------------------
// tb_el2_dec_pmp_scan_ctl
//
// Scoreboard bench: each driven request pushes its expected {id, err, entry,
// latency}; a monitor records accept cycles, measures rsp_valid rise latency
// and pops/compares at every response handshake. It also flags any grant
// while a request is in flight.
// ---------------------------------------------------------------------------
module tb_el2_dec_pmp_scan_ctl;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0][31:0]  req_addr;
  logic [1:0][1:0]   req_acc;
  logic [1:0]        req_umode;
  logic [1:0]        req_ready;
  logic [15:0][7:0]  pmp_pmpcfg;
  logic [15:0][31:0] pmp_pmpaddr;
  logic              pmp_cfg_wr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic              rsp_err;
  logic [5:0]        rsp_entry;

  el2_dec_pmp_scan_ctl #(
    .PMP_ENTRIES      (16),
    .ENTRIES_PER_CYCLE(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_acc    (req_acc),
    .req_umode  (req_umode),
    .req_ready  (req_ready),
    .pmp_pmpcfg (pmp_pmpcfg),
    .pmp_pmpaddr(pmp_pmpaddr),
    .pmp_cfg_wr (pmp_cfg_wr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .rsp_entry  (rsp_entry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic       err;
    logic [5:0] entry;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   t_grant  = 0;
  int   rise_lat = 0;
  logic busy     = 1'b0;
  logic prev_rv  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic id, input logic err, input logic [5:0] entry, input int lat);
    exp_t e;
    e.id = id; e.err = err; e.entry = entry; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge: wait for the grant, then drop valid next cycle.
  task automatic wait_drop(input logic id);
    int n = 0;
    #1;
    while (!req_ready[id] && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check("grant_seen", 32'(req_ready[id]), 32'd1);
    t_grant = cyc;
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic send(input logic id, input logic [31:0] addr, input logic [1:0] acc,
                      input logic um, input logic err, input logic [5:0] entry, input int lat);
    push_exp(id, err, entry, lat);
    req_addr[id]  = addr;
    req_acc[id]   = acc;
    req_umode[id] = um;
    req_valid[id] = 1'b1;
    wait_drop(id);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); #3;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: sampled well after the falling edge, away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      busy    = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (busy) check("grant_while_busy", 32'(req_ready), 32'd0);
      if (|(req_valid & req_ready)) begin
        acc_q.push_back(cyc);
        busy = 1'b1;
      end
      if (rsp_valid && !prev_rv) begin
        check("rsp_pending_req", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() != 0) rise_lat = cyc - acc_q.pop_front();
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_entry", 32'(rsp_entry), 32'(e.entry));
          check("rsp_latency", 32'(rise_lat), 32'(e.lat));
        end
        busy = 1'b0;
      end
      prev_rv = rsp_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    req_valid   = 2'b11;
    req_addr    = '0;
    req_acc     = '0;
    req_umode   = '0;
    pmp_pmpcfg  = '0;
    pmp_pmpaddr = '0;
    pmp_cfg_wr  = 1'b0;
    rsp_ready   = 1'b1;

    // Reset state, with both requesters pushing.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_entry", 32'(rsp_entry), 32'h3F);
    rst       = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);

    // NAPOT entry 2 covering 0x1000_0000..0x1000_07FF.
    pmp_pmpcfg[2]  = 8'h1B;
    pmp_pmpaddr[2] = 32'h0400_00FF;
    send(1'b0, 32'h1000_0400, 2'd0, 1'b1, 1'b0, 6'd2, 2);
    drain();
    pmp_pmpcfg[2] = 8'h19;
    send(1'b0, 32'h1000_0400, 2'd1, 1'b1, 1'b1, 6'd2, 2);
    drain();

    // TOR entry 5 over words 0x0800_0000..0x0800_03FF.
    pmp_pmpcfg[2]  = 8'h00;
    pmp_pmpaddr[4] = 32'h0800_0000;
    pmp_pmpaddr[5] = 32'h0800_0400;
    pmp_pmpcfg[5]  = 8'h0F;
    send(1'b0, 32'h2000_0FFC, 2'd2, 1'b1, 1'b0, 6'd5, 3);
    drain();
    send(1'b0, 32'h2000_1000, 2'd2, 1'b1, 1'b1, 6'h3F, 5);
    drain();
    send(1'b0, 32'h2000_1000, 2'd2, 1'b0, 1'b0, 6'h3F, 5);
    drain();

    // All-ones NAPOT in the last entry matches anything (upper bits ignored).
    pmp_pmpcfg[15]  = 8'h1F;
    pmp_pmpaddr[15] = 32'hFFFF_FFFF;
    send(1'b0, 32'h2000_1000, 2'd0, 1'b1, 1'b0, 6'd15, 5);
    drain();
    pmp_pmpcfg[15] = 8'h00;

    // NA4 entry 0, read-only: lock bit decides M-mode write outcome.
    pmp_pmpcfg[0]  = 8'h11;
    pmp_pmpaddr[0] = 32'h0000_0100;
    send(1'b0, 32'h0000_0400, 2'd1, 1'b0, 1'b0, 6'd0, 2);
    drain();
    pmp_pmpcfg[0] = 8'h91;
    send(1'b0, 32'h0000_0400, 2'd1, 1'b0, 1'b1, 6'd0, 2);
    drain();
    // Reserved access type is denied even on an unlocked M-mode hit.
    pmp_pmpcfg[0] = 8'h11;
    send(1'b1, 32'h0000_0400, 2'd3, 1'b0, 1'b1, 6'd0, 2);
    drain();

    // Both requesters valid continuously: grants alternate 0,1,0,1.
    pmp_pmpcfg[2] = 8'h19;
    pmp_pmpcfg[5] = 8'h00;
    req_addr[0] = 32'h0000_0400; req_acc[0] = 2'd0; req_umode[0] = 1'b0;
    req_addr[1] = 32'h1000_0400; req_acc[1] = 2'd1; req_umode[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(1'b0, 1'b0, 6'd0, 2);
      else            push_exp(1'b1, 1'b1, 6'd2, 2);
    end
    req_valid = 2'b11;
    begin
      int grants = 0;
      int n      = 0;
      while (grants < 4 && n < 60) begin
        #1;
        if (|req_ready) begin
          check("alt_grant", 32'(req_ready), (grants % 2 == 0) ? 32'd1 : 32'd2);
          grants++;
        end
        @(negedge clk);
        n++;
      end
      check("alt_grant_count", 32'(grants), 32'd4);
    end
    req_valid = 2'b00;
    drain();

    // CSR write mid-scan restarts the scan; response then held 5 cycles.
    pmp_pmpcfg[0] = 8'h00;
    pmp_pmpcfg[2] = 8'h00;
    pmp_pmpcfg[5] = 8'h0F;
    rsp_ready     = 1'b0;
    send(1'b0, 32'h2000_1000, 2'd2, 1'b1, 1'b1, 6'h3F, 7);
    @(negedge clk);
    pmp_cfg_wr = 1'b1;
    @(negedge clk);
    pmp_cfg_wr = 1'b0;
    push_exp(1'b1, 1'b0, 6'd5, 3);
    req_addr[1] = 32'h2000_0FFC; req_acc[1] = 2'd2; req_umode[1] = 1'b1;
    req_valid[1] = 1'b1;
    begin
      int n = 0;
      #1;
      while (!rsp_valid && n < 30) begin
        @(negedge clk); #1;
        n++;
      end
    end
    check("cfgwr_rise_cycle", 32'(cyc - t_grant), 32'd7);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_err", 32'(rsp_err), 32'd1);
      check("hold_entry", 32'(rsp_entry), 32'h3F);
      check("hold_id", 32'(rsp_id), 32'd0);
      check("hold_no_grant", 32'(req_ready), 32'd0);
      pmp_cfg_wr = (k == 1);
      @(negedge clk); #1;
    end
    pmp_cfg_wr = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    wait_drop(1'b1);
    drain();

    // Reset in the middle of a scan drops the request without a response.
    send(1'b0, 32'h2000_1000, 2'd2, 1'b1, 1'b1, 6'h3F, 5);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_rsp_entry", 32'(rsp_entry), 32'h3F);
    push_exp(1'b0, 1'b1, 6'h3F, 5);
    push_exp(1'b1, 1'b0, 6'd5, 3);
    wait_drop(1'b0);
    wait_drop(1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
